// File: rtl/inst_fetch_unit_pkg.sv
// Shared ISA constants, IR field positions and fetch FSM states
// for the fetch stage and the control unit.
package inst_fetch_unit_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ALU  = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_JUMP = 6'd5;

  localparam int IR_RI_HI  = 25;
  localparam int IR_RI_LO  = 21;
  localparam int IR_RK_HI  = 20;
  localparam int IR_RK_LO  = 16;
  localparam int IR_I26_HI = 25;
  localparam int IR_I16_HI = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/ack bus between fetch stage
// (master) and instruction memory (slave).
interface inst_fetch_unit_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 32
);
  logic                 imem_req;
  logic [ADDR_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [DATA_SIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch_unit_imm_extend.sv
// Immediate extractor: sign-extends IR[25:0] or IR[15:0]
// to full data width, selected by ext_sel.
module inst_fetch_unit_imm_extend
  import inst_fetch_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0] i_ir,
  input  logic                 i_ext_sel,
  output logic [DATA_SIZE-1:0] o_imme
);

  logic [DATA_SIZE-1:0] w_imm26;
  logic [DATA_SIZE-1:0] w_imm16;

  assign w_imm26 = {{(DATA_SIZE-IR_I26_HI-1){i_ir[IR_I26_HI]}},
                    i_ir[IR_I26_HI:0]};
  assign w_imm16 = {{(DATA_SIZE-IR_I16_HI-1){i_ir[IR_I16_HI]}},
                    i_ir[IR_I16_HI:0]};
  assign o_imme  = i_ext_sel ? w_imm26 : w_imm16;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, IR and handshaked instruction fetch,
// one instruction per ISSUE cycle, sticky halt on error.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_SIZE   = 8,
  parameter int DATA_SIZE   = 32,
  parameter int CODE_SIZE   = 6,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  inst_fetch_unit_if.master    imem,
  input  logic                 pc_sel,
  input  logic                 ext_sel,
  output logic                 instr_valid,
  output logic [CODE_SIZE-1:0] i_code,
  output logic [4:0]           ri,
  output logic [4:0]           rk,
  output logic [DATA_SIZE-1:0] imme,
  output logic [ADDR_SIZE-1:0] pc,
  output logic                 halted
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  fetch_state_e         r_state;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [DATA_SIZE-1:0] r_ir;
  logic                 r_req;
  logic                 r_valid;
  logic                 r_halted;
  logic [TW-1:0]        r_timer;

  logic [ADDR_SIZE-1:0] w_pc_inc;
  logic [ADDR_SIZE-1:0] w_next_pc;
  logic [CODE_SIZE-1:0] w_rd_op;
  logic                 w_rd_legal;
  logic                 w_timeout;
  logic [DATA_SIZE-1:0] w_imme;

  inst_fetch_unit_imm_extend #(
    .DATA_SIZE (DATA_SIZE)
  ) u_imm (
    .i_ir      (r_ir),
    .i_ext_sel (ext_sel),
    .o_imme    (w_imme)
  );

  // Branch target arithmetic wraps modulo the address space.
  assign w_pc_inc   = r_pc + ADDR_SIZE'(1);
  assign w_next_pc  = pc_sel ? w_pc_inc + w_imme[ADDR_SIZE-1:0]
                             : w_pc_inc;
  assign w_rd_op    = imem.imem_rdata[DATA_SIZE-1 -: CODE_SIZE];
  assign w_rd_legal = (w_rd_op <= CODE_SIZE'(OP_JUMP));
  assign w_timeout  = (r_timer == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= ADDR_SIZE'(RESET_PC);
      r_ir     <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_timer  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_timer <= '0;
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            r_ir    <= imem.imem_rdata;
            r_timer <= '0;
            r_req   <= 1'b0;
            if (w_rd_legal) begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
            end else begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= S_HALT;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_state <= S_FETCH;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
          end
        end
        S_HALT: begin
          r_req    <= 1'b0;
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr_valid    = r_valid;
  assign halted         = r_halted;
  assign pc             = r_pc;
  assign i_code         = r_ir[DATA_SIZE-1 -: CODE_SIZE];
  assign ri             = r_ir[IR_RI_HI:IR_RI_LO];
  assign rk             = r_ir[IR_RK_HI:IR_RK_LO];
  assign imme           = w_imme;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed and random instruction
// streams checked against a behavioural PC/IR model.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic        ext_sel = 1'b0;
  logic        instr_valid;
  logic [5:0]  i_code;
  logic [4:0]  ri;
  logic [4:0]  rk;
  logic [31:0] imme;
  logic [7:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_pc;

  inst_fetch_unit_if #(.ADDR_SIZE(8), .DATA_SIZE(32)) imem ();

  inst_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .imem        (imem),
    .pc_sel      (pc_sel),
    .ext_sel     (ext_sel),
    .instr_valid (instr_valid),
    .i_code      (i_code),
    .ri          (ri),
    .rk          (rk),
    .imme        (imme),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic longint imm_val(input logic [31:0] w,
                                     input logic e);
    longint v;
    if (e) begin
      v = longint'(w & 32'h03FF_FFFF);
      if (v >= 64'sd33554432) v = v - 64'sd67108864;
    end else begin
      v = longint'(w & 32'h0000_FFFF);
      if (v >= 64'sd32768) v = v - 64'sd65536;
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_next(input logic [7:0] p,
      input logic [31:0] w, input logic ps, input logic e);
    longint t;
    t = longint'(p) + 1;
    if (ps) t = t + imm_val(w, e);
    return 8'(t & 64'sd255);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    stall = 1'b0;
    tick();
    chk("rst_req", 32'(imem.imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_icode", 32'(i_code), 0);
    rst_n = 1'b1;
    tick();
    m_pc = 8'h00;
  endtask

  task automatic do_instr(input logic [31:0] w, input int wn,
      input logic ps, input logic e, input int ns);
    chk("fetch_req", 32'(imem.imem_req), 1);
    chk("fetch_addr", 32'(imem.imem_addr), 32'(m_pc));
    chk("fetch_valid", 32'(instr_valid), 0);
    for (int i = 0; i < wn; i++) begin
      imem.imem_ack = 1'b0;
      tick();
      chk("wait_req", 32'(imem.imem_req), 1);
      chk("wait_valid", 32'(instr_valid), 0);
    end
    imem.imem_ack = 1'b1;
    imem.imem_rdata = w;
    tick();
    imem.imem_ack = 1'b0;
    imem.imem_rdata = $urandom;
    ext_sel = e;
    #1;
    chk("iss_valid", 32'(instr_valid), 1);
    chk("iss_req", 32'(imem.imem_req), 0);
    chk("iss_icode", 32'(i_code), 32'(w >> 26));
    chk("iss_ri", 32'(ri), (w >> 21) & 32'h1F);
    chk("iss_rk", 32'(rk), (w >> 16) & 32'h1F);
    chk("iss_imme", imme, 32'(imm_val(w, e)));
    chk("iss_pc", 32'(pc), 32'(m_pc));
    for (int i = 0; i < ns; i++) begin
      stall = 1'b1;
      pc_sel = 1'($urandom);
      imem.imem_ack = 1'($urandom);
      tick();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_req", 32'(imem.imem_req), 0);
      chk("stall_pc", 32'(pc), 32'(m_pc));
      chk("stall_icode", 32'(i_code), 32'(w >> 26));
    end
    imem.imem_ack = 1'b0;
    stall = 1'b0;
    pc_sel = ps;
    ext_sel = e;
    tick();
    m_pc = ref_next(m_pc, w, ps, e);
    pc_sel = 1'($urandom);
    ext_sel = 1'($urandom);
    stall = 1'($urandom);
    #1;
    chk("next_pc", 32'(pc), 32'(m_pc));
    chk("next_addr", 32'(imem.imem_addr), 32'(m_pc));
    chk("next_req", 32'(imem.imem_req), 1);
    chk("next_valid", 32'(instr_valid), 0);
    stall = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] w;
    logic [15:0] d;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    do_reset();

    do_instr({OP_ALU, 5'd3, 5'd4, 16'h1234}, 2, 1'b0, 1'b0, 0);
    do_instr({OP_JUMP, 26'd14}, 0, 1'b1, 1'b1, 0);
    do_instr({OP_JUMP, 26'h3FF_FFFE}, 1, 1'b1, 1'b1, 0);
    do_instr({OP_JUMP, 26'h10}, 0, 1'b1, 1'b1, 0);
    do_instr({OP_BEQ, 5'd1, 5'd2, 16'h0005}, 0, 1'b0, 1'b0, 0);
    do_instr({OP_JUMP, 26'h3FF_FFFE}, 0, 1'b1, 1'b1, 0);
    do_instr({OP_BEQ, 5'd1, 5'd2, 16'h0005}, 1, 1'b1, 1'b0, 0);
    do_instr({OP_ALU, 5'd7, 5'd9, 16'hBEEF}, 0, 1'b0, 1'b0, 4);
    do_instr(32'h0000_0000, 0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      w = {6'($urandom_range(0, 5)), r[25:0]};
      do_instr(w, $urandom_range(0, 3), 1'($urandom),
               1'($urandom), $urandom_range(0, 2));
    end

    d = 16'(8'(8'hFE - m_pc));
    do_instr({OP_BEQ, 5'd0, 5'd0, d}, 0, 1'b1, 1'b0, 0);
    do_instr({OP_NOP, 26'h0}, 0, 1'b0, 1'b0, 0);

    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hFC00_0000;
    tick();
    imem.imem_ack = 1'b0;
    chk("ill_halted", 32'(halted), 1);
    chk("ill_valid", 32'(instr_valid), 0);
    chk("ill_req", 32'(imem.imem_req), 0);
    for (int i = 0; i < 6; i++) begin
      imem.imem_ack = 1'($urandom);
      stall = 1'($urandom);
      tick();
      chk("halt_req", 32'(imem.imem_req), 0);
      chk("halt_valid", 32'(instr_valid), 0);
      chk("halt_sticky", 32'(halted), 1);
    end
    stall = 1'b0;

    do_reset();
    chk("to_req0", 32'(imem.imem_req), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_waiting", 32'(halted), 0);
    end
    tick();
    chk("to_halted", 32'(halted), 1);
    chk("to_req", 32'(imem.imem_req), 0);

    do_reset();
    do_instr({OP_LW, 5'd2, 5'd3, 16'h0004}, 0, 1'b0, 1'b0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = {OP_ALU, 26'h0};
    #1;
    chk("midrst_req", 32'(imem.imem_req), 0);
    chk("midrst_pc", 32'(pc), 0);
    tick();
    chk("midrst_valid", 32'(instr_valid), 0);
    imem.imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    m_pc = 8'h00;
    do_instr({OP_SW, 5'd4, 5'd5, 16'hFFFF}, 1, 1'b1, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
